fpdp_power: RTL and testbench
=============================

FPDP_POWER -- requirements
Module: fpdp_power

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rset  input  1  asynchronous active-low reset.
REQ-003 SHALL have port power_input  input  64  IEEE 754 double operand x, sampled when a start is accepted.
REQ-004 SHALL have port power_n  input  5  unsigned integer exponent n (0..31), sampled with power_input.
REQ-005 SHALL have port ready  input  1  start strobe; accepted only in IDLE.
REQ-006 SHALL have port power_output  output  64  double result x^n, feeds fpdp_reciprocal rcprcl_input.
REQ-007 SHALL have port done  output  1  one-cycle pulse, power_output valid from that cycle.
REQ-008 SHALL have port busy  output  1  high from accepted start until the cycle after done.
REQ-009 SHALL have parameter MUL_LAT, default 2, meaning fpdp_multiplier latency in cycles.

Function
REQ-010 SHALL compute x^n by left-to-right square-and-multiply: acc=1.0; for bit i=4..0: acc=acc*acc, then if n[i] acc=acc*x.
REQ-011 SHALL use FSM states IDLE, LOAD, SQUARE, MULT, FINISH; IDLE->LOAD on ready; LOAD->SQUARE; SQUARE->MULT if n[i] else next bit/FINISH; MULT->SQUARE (next bit) or FINISH after bit 0; FINISH->IDLE.
REQ-012 SHALL process all five bits unconditionally (no leading-zero skip).
REQ-013 SHALL assert done exactly 2 + 5*MUL_LAT + popcount(n)*MUL_LAT rising edges after the edge that samples ready=1 (16 for n=3, MUL_LAT=2).
REQ-014 SHALL ignore ready while busy=1; operands SHALL not be resampled mid-operation.
REQ-015 SHALL hold power_output stable from done until the next done; ready SHALL be accepted in the cycle after done.
REQ-016 SHALL return 1.0 (0x3FF0000000000000) for n=0, for any x when FPDP_POWER_SPECIAL_EN is defined.
REQ-017 Multiplies SHALL round to nearest-even, flush denormal inputs/results to signed zero, saturate overflow to signed infinity.
REQ-018 Result sign SHALL equal sign(x) AND n[0].
REQ-019 Exponent arithmetic SHALL use a 13-bit signed intermediate so overflow/underflow are detected without wrap.

Reset
REQ-020 rset low SHALL immediately force state IDLE, power_output=0, done=0, busy=0, acc and counters to 0.
REQ-021 Reset during any non-IDLE state SHALL abort the operation with no done pulse after release.
REQ-022 First start SHALL be accepted on the first rising edge with rset high and ready high.

Configuration
REQ-023 Macro FPDP_POWER_SPECIAL_EN defined: NaN x gives 0x7FF8000000000000 (n!=0); +/-Inf gives signed Inf; +/-0 gives signed zero (n!=0); latency unchanged.
REQ-024 Macro undefined: exponent field 0x7FF treated as ordinary; result for NaN/Inf inputs unspecified, all other REQs hold.

Structure
REQ-025 Package fpdp_pkg SHALL hold FP_ONE, FP_QNAN, FP_PINF, field widths (sign 1, exp 11, frac 52), exponent bias 1023, and FSM state encoding.
REQ-026 Multiplication SHALL live in sub-module fpdp_multiplier (registered, MUL_LAT cycles, start/done handshake), shared by squaring and multiply steps.

Verification
REQ-027 x=0x4000000000000000 (2.0), n=5 -> 0x4040000000000000 (32.0), done at edge 16.
REQ-028 x=0x3FF8000000000000 (1.5), n=3 -> 0x400B000000000000 (3.375); x=0xC000000000000000 (-2.0), n=3 -> 0xC020000000000000.
REQ-029 n=0, x=0x40D8E07288CE703B -> 0x3FF0000000000000, done at edge 12.
REQ-030 x=0x7E37E43C8800759C (~1e300), n=2 -> 0x7FF0000000000000; x=0x0010000000000000, n=2 -> 0x0000000000000000.
REQ-031 rset low at edge 6 of n=31 run -> outputs 0 immediately, no done; new start after release completes normally.
REQ-032 ready held high continuously -> back-to-back operations, second start accepted the cycle after first done, busy low exactly one cycle between.

Source files
------------

// File: rtl/fpdp_pkg.sv
// Shared constants, field widths and FSM encoding for the double-precision power unit.
package fpdp_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 11;
  localparam int FRAC_W   = 52;
  localparam int FP_W     = SIGN_W + EXP_W + FRAC_W;
  localparam int EXP_BIAS = 1023;

  localparam logic [FP_W-1:0] FP_ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [FP_W-1:0] FP_PINF = 64'h7FF0_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SQUARE = 3'd2,
    ST_MULT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/fpdp_multiplier.sv
// Double-precision multiplier: round-to-nearest-even, denormal flush to signed zero,
// overflow saturates to signed infinity. Result and done appear MUL_LAT cycles after start.
module fpdp_multiplier
  import fpdp_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rset,
  input  logic            start,
  input  logic [FP_W-1:0] op_a,
  input  logic [FP_W-1:0] op_b,
  output logic            done,
  output logic [FP_W-1:0] result
);

  logic                sign;
  logic [EXP_W-1:0]    ea, eb;
  logic [FRAC_W:0]     ma, mb;
  logic [2*FRAC_W+1:0] prod;
  logic [FRAC_W:0]     mant;
  logic                guard, sticky;
  logic [FRAC_W+1:0]   mant_rnd;
  logic [FRAC_W-1:0]   frac;
  logic signed [12:0]  exp_s;
  logic [FP_W-1:0]     result_c;

  always_comb begin
    sign   = op_a[FP_W-1] ^ op_b[FP_W-1];
    ea     = op_a[FP_W-2:FRAC_W];
    eb     = op_b[FP_W-2:FRAC_W];
    ma     = {1'b1, op_a[FRAC_W-1:0]};
    mb     = {1'b1, op_b[FRAC_W-1:0]};
    prod   = {53'd0, ma} * {53'd0, mb};
    // 13-bit signed exponent keeps overflow and underflow visible without wrapping
    exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
    if (prod[2*FRAC_W+1]) begin
      mant   = prod[105:53];
      guard  = prod[52];
      sticky = |prod[51:0];
      exp_s  = exp_s + 13'sd1;
    end else begin
      mant   = prod[104:52];
      guard  = prod[51];
      sticky = |prod[50:0];
    end
    mant_rnd = {1'b0, mant} + {53'd0, guard & (sticky | mant[0])};
    if (mant_rnd[FRAC_W+1]) begin
      exp_s = exp_s + 13'sd1;
      frac  = mant_rnd[FRAC_W:1];
    end else begin
      frac  = mant_rnd[FRAC_W-1:0];
    end
    if (ea == '0 || eb == '0 || exp_s <= 13'sd0)
      result_c = {sign, 63'd0};
    else if (exp_s >= 13'sd2047)
      result_c = {sign, 11'h7FF, 52'd0};
    else
      result_c = {sign, exp_s[EXP_W-1:0], frac};
  end

  generate
    if (MUL_LAT <= 1) begin : g_comb
      assign done   = start;
      assign result = result_c;
    end else begin : g_pipe
      logic [MUL_LAT-2:0] valid_reg;
      logic [FP_W-1:0]    res_reg [MUL_LAT-1];

      always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
          valid_reg <= '0;
          for (int i = 0; i < MUL_LAT-1; i++) res_reg[i] <= '0;
        end else begin
          valid_reg[0] <= start;
          res_reg[0]   <= result_c;
          for (int i = 1; i < MUL_LAT-1; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            res_reg[i]   <= res_reg[i-1];
          end
        end
      end

      assign done   = valid_reg[MUL_LAT-2];
      assign result = res_reg[MUL_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/fpdp_power.sv
// x^n for doubles by left-to-right square-and-multiply over all five bits of n.
// Optional FPDP_POWER_SPECIAL_EN adds NaN/Inf/zero operand handling at the result.
module fpdp_power
  import fpdp_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rset,
  input  logic [FP_W-1:0] power_input,
  input  logic [4:0]      power_n,
  input  logic            ready,
  output logic [FP_W-1:0] power_output,
  output logic            done,
  output logic            busy
);

  state_t          state_reg, state_next;
  logic [2:0]      bit_reg;
  logic [4:0]      n_reg;
  logic [FP_W-1:0] x_reg, acc_reg, out_reg;
  logic            done_reg, start_reg, start_next;
  logic            mul_done;
  logic [FP_W-1:0] mul_b, mul_result, final_result;
  logic [7:0]      n_ext;
  logic            cur_bit, last_bit, bit_adv;

  fpdp_multiplier #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk    (clk),
    .rset   (rset),
    .start  (start_reg),
    .op_a   (acc_reg),
    .op_b   (mul_b),
    .done   (mul_done),
    .result (mul_result)
  );

  assign n_ext    = {3'b000, n_reg};
  assign cur_bit  = n_ext[bit_reg];
  assign last_bit = (bit_reg == 3'd0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (ready) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_SQUARE;
      ST_SQUARE: if (mul_done) begin
                   if (cur_bit)       state_next = ST_MULT;
                   else if (last_bit) state_next = ST_FINISH;
                   else               state_next = ST_SQUARE;
                 end
      ST_MULT:   if (mul_done) state_next = last_bit ? ST_FINISH : ST_SQUARE;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_reg != ST_IDLE);
    mul_b      = (state_reg == ST_MULT) ? x_reg : acc_reg;
    // Launch one multiply on entry to every SQUARE/MULT step
    start_next = (state_next == ST_SQUARE || state_next == ST_MULT) &&
                 (state_reg == ST_LOAD || mul_done);
    bit_adv    = mul_done && !last_bit &&
                 ((state_reg == ST_SQUARE && !cur_bit) || state_reg == ST_MULT);
  end

`ifdef FPDP_POWER_SPECIAL_EN
  always_comb begin
    final_result = acc_reg;
    if (n_reg != 5'd0) begin
      if (x_reg[62:52] == 11'h7FF && x_reg[51:0] != '0)
        final_result = FP_QNAN;
      else if (x_reg[62:52] == 11'h7FF)
        final_result = {x_reg[63] & n_reg[0], 11'h7FF, 52'd0};
      else if (x_reg[62:0] == '0)
        final_result = {x_reg[63] & n_reg[0], 63'd0};
    end
  end
`else
  assign final_result = acc_reg;
`endif

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state_reg <= ST_IDLE;
      bit_reg   <= '0;
      n_reg     <= '0;
      x_reg     <= '0;
      acc_reg   <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_next;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: if (ready) begin
          x_reg <= power_input;
          n_reg <= power_n;
        end
        ST_LOAD: begin
          acc_reg <= FP_ONE;
          bit_reg <= 3'd4;
        end
        ST_SQUARE, ST_MULT: if (mul_done) begin
          acc_reg <= mul_result;
          if (bit_adv) bit_reg <= bit_reg - 3'd1;
        end
        ST_FINISH: begin
          out_reg  <= final_result;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign power_output = out_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_fpdp_power.sv
// Directed vector bench for fpdp_power: result values, done latency, reset abort
// and back-to-back operation with ready held high.
module tb_fpdp_power;

  logic        clk = 1'b0;
  logic        rset = 1'b0;
  logic        ready = 1'b0;
  logic [63:0] power_input = '0;
  logic [4:0]  power_n = '0;
  logic [63:0] power_output;
  logic        done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] x;
    logic [4:0]  n;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [15];

  fpdp_power #(.MUL_LAT(2)) dut (
    .clk          (clk),
    .rset         (rset),
    .power_input  (power_input),
    .power_n      (power_n),
    .ready        (ready),
    .power_output (power_output),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Caller is at a negedge; the next posedge samples ready (edge 0)
  task automatic run_op(input logic [63:0] x, input logic [4:0] n,
                        output logic [63:0] res, output int lat);
    power_input = x;
    power_n     = n;
    ready       = 1'b1;
    @(posedge clk);
    #1;
    ready       = 1'b0;
    power_input = ~x;
    power_n     = ~n;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = power_output;
  endtask

  initial begin
    logic [63:0] res, res1;
    int lat, k, first_done, second_done, busy_low, dones;

    vecs[0]  = '{64'h4000000000000000, 5'd5,  64'h4040000000000000, 16};
    vecs[1]  = '{64'h3FF8000000000000, 5'd3,  64'h400B000000000000, 16};
    vecs[2]  = '{64'hC000000000000000, 5'd3,  64'hC020000000000000, 16};
    vecs[3]  = '{64'h40D8E07288CE703B, 5'd0,  64'h3FF0000000000000, 12};
    vecs[4]  = '{64'h7E37E43C8800759C, 5'd2,  64'h7FF0000000000000, 14};
    vecs[5]  = '{64'h0010000000000000, 5'd2,  64'h0000000000000000, 14};
    vecs[6]  = '{64'hBFF0000000000000, 5'd31, 64'hBFF0000000000000, 22};
    vecs[7]  = '{64'h3FE0000000000000, 5'd31, 64'h3E00000000000000, 22};
    vecs[8]  = '{64'h3FF0000003000000, 5'd2,  64'h3FF0000006000001, 14};
    vecs[9]  = '{64'h4008000000000000, 5'd2,  64'h4022000000000000, 14};
    vecs[10] = '{64'hC008000000000000, 5'd2,  64'h4022000000000000, 14};
    vecs[11] = '{64'h4000000000000000, 5'd1,  64'h4000000000000000, 14};
    vecs[12] = '{64'hBFE0000000000000, 5'd1,  64'hBFE0000000000000, 14};
    vecs[13] = '{64'hFE37E43C8800759C, 5'd3,  64'hFFF0000000000000, 16};
    vecs[14] = '{64'h8000000000000000, 5'd3,  64'h8000000000000000, 16};

    #1;
    check64("reset_output", power_output, 64'h0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      run_op(vecs[i].x, vecs[i].n, res, lat);
      $display("vec %0d: x=%h n=%0d -> %h after %0d edges", i, vecs[i].x, vecs[i].n, res, lat);
      check64($sformatf("vec%0d_result", i), res, vecs[i].res);
      check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      @(posedge clk);
      #1;
      check_int($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      check64($sformatf("vec%0d_hold", i), power_output, vecs[i].res);
    end

    // Reset in the middle of an n=31 run
    @(negedge clk);
    power_input = 64'h3FF0000000000000;
    power_n     = 5'd31;
    ready       = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_int("abort_busy_before", int'(busy), 1);
    rset = 1'b0;
    #1;
    check64("abort_output", power_output, 64'h0);
    check_int("abort_done", int'(done), 0);
    check_int("abort_busy", int'(busy), 0);
    @(negedge clk);
    rset = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check_int("abort_no_done", dones, 0);
    $display("abort: %0d done pulses after release", dones);
    @(negedge clk);
    run_op(64'h4000000000000000, 5'd3, res, lat);
    $display("after abort: 2.0^3 -> %h after %0d edges", res, lat);
    check64("recover_result", res, 64'h4020000000000000);
    check_int("recover_latency", lat, 16);

    // Back-to-back with ready held high; operands change after the first accept
    @(negedge clk);
    power_input = 64'h4000000000000000;
    power_n     = 5'd5;
    ready       = 1'b1;
    @(posedge clk);
    #1;
    power_input = 64'h4008000000000000;
    k = 0; first_done = -1; second_done = -1; busy_low = 0; res1 = '0;
    while (second_done < 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (first_done >= 0 && busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin
        if (first_done < 0) begin
          first_done = k;
          res1 = power_output;
        end else begin
          second_done = k;
        end
      end
    end
    ready = 1'b0;
    $display("back-to-back: done at %0d and %0d, results %h %h, busy low %0d", first_done, second_done, res1, power_output, busy_low);
    check_int("b2b_first_done", first_done, 16);
    check64("b2b_first_result", res1, 64'h4040000000000000);
    check_int("b2b_second_done", second_done, 33);
    check64("b2b_second_result", power_output, 64'h406E600000000000);
    check_int("b2b_busy_low", busy_low, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
